// File: rtl/mips_defs.sv
// Shared definitions for the fetch front end: FSM state encodings and
// the PC step/alignment constants.
package mips_defs;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [31:0] PC_INC          = 32'd4;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_adder4.sv
// 32-bit +4 incrementer; the carry out is dropped so the PC wraps modulo 2^32.
module pc_adder4
    import mips_defs::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] sum_o
);

    assign sum_o = pc_i + PC_INC;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and fetch/execute sequencer: issues one instruction
// fetch, holds the word for decode, then retires it to the next PC.
module pc_fetch_sequencer
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      next_pc_in,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic [3:0]       pc_plus4_upper,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             align_err
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [31:0]      link_q, link_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      target;
    logic [31:0]      pc_inc;

    pc_adder4 u_adder4 (
        .pc_i  (pc_q),
        .sum_o (pc_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            link_q  <= 32'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            link_q  <= link_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        link_d  = link_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        target  = redirect ? next_pc_in : pc_inc;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A stalled instruction freezes everything, including the redirect inputs.
                if (!stall) begin
                    valid_d = 1'b0;
                    if ((target[1:0] & WORD_ALIGN_MASK) != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        pc_d    = target;
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = ST_FETCH;
                        if (redirect) begin
                            link_d = pc_inc;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_ERR;
                valid_d = 1'b0;
            end
        endcase
    end

    // Request is decoded from the registered state so reset drops it immediately.
    assign imem_req       = (state_q == ST_FETCH);
    assign imem_addr      = pc_q;
    assign instr_out      = instr_q;
    assign instr_valid    = valid_q;
    assign pc_out         = pc_q;
    assign pc_plus4       = pc_inc;
    assign pc_plus4_upper = pc_inc[31:28];
    assign link_addr      = link_q;
    assign retired_cnt    = cnt_q;
    assign align_err      = err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Transaction-level bench: each instruction is fetched, optionally stalled and
// retired, and every cycle is compared with a simple architectural model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] next_pc_in = 32'd0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [3:0]  pc_plus4_upper;
    logic [31:0] link_addr;
    logic [31:0] retired_cnt;
    logic        align_err;

    pc_fetch_sequencer #(.RESET_VECTOR(RV), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .redirect       (redirect),
        .next_pc_in     (next_pc_in),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .pc_plus4_upper (pc_plus4_upper),
        .link_addr      (link_addr),
        .retired_cnt    (retired_cnt),
        .align_err      (align_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // architectural model
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_link;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_common();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        chk("pc_out", pc_out, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_plus4", pc_plus4, p4);
        chk("pc_plus4_upper", {28'd0, pc_plus4_upper}, {28'd0, p4[31:28]});
        chk("retired_cnt", retired_cnt, m_cnt);
        chk("link_addr", link_addr, m_link);
        chk("align_err", {31'd0, align_err}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_pc = RV; m_cnt = 32'd0; m_link = 32'd0; m_err = 1'b0;
        check_common();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        step();
    endtask

    // One instruction: fetch wait, ready, stall cycles, then retire.
    task automatic run_instr(input int delay, input int stalls, input bit redir,
                             input logic [31:0] tgt);
        logic [31:0] word;
        logic [31:0] t;
        for (int i = 0; i < delay; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            check_common();
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        word = $urandom;
        imem_ready = 1'b1;
        imem_rdata = word;
        check_common();
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
        step();
        for (int i = 0; i <= stalls; i++) begin
            imem_ready = 1'($urandom % 2);
            imem_rdata = $urandom;
            check_common();
            chk("exec_req", {31'd0, imem_req}, 32'd0);
            chk("exec_valid", {31'd0, instr_valid}, 32'd1);
            chk("instr_out", instr_out, word);
            if (i < stalls) begin
                stall = 1'b1;
                redirect = 1'($urandom % 2);
                next_pc_in = $urandom;
            end else begin
                stall = 1'b0;
                redirect = redir;
                next_pc_in = tgt;
            end
            step();
        end
        t = redir ? tgt : m_pc + 32'd4;
        if (t[1:0] != 2'b00) begin
            m_err = 1'b1;
        end else begin
            if (redir) m_link = m_pc + 32'd4;
            m_pc = t;
            m_cnt = m_cnt + 32'd1;
        end
        imem_ready = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        next_pc_in = 32'd0;
        if (m_err) begin
            for (int i = 0; i < 3; i++) begin
                imem_ready = 1'($urandom % 2);
                redirect = 1'($urandom % 2);
                next_pc_in = $urandom & 32'hFFFF_FFFC;
                check_common();
                chk("err_req", {31'd0, imem_req}, 32'd0);
                chk("err_valid", {31'd0, instr_valid}, 32'd0);
                step();
            end
            imem_ready = 1'b0;
            redirect = 1'b0;
            next_pc_in = 32'd0;
        end
    endtask

    initial begin
        #12;
        do_reset();

        for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 32'd0);
        chk("cnt_after_3", retired_cnt, 32'd3);
        chk("pc_after_3", pc_out, 32'h0000_000C);

        run_instr(3, 0, 1'b0, 32'd0);

        run_instr(0, 0, 1'b1, 32'h0040_0020);
        run_instr(1, 0, 1'b1, 32'h0040_0100);
        chk("jal_link", link_addr, 32'h0040_0024);
        chk("jal_target", imem_addr, 32'h0040_0100);

        run_instr(0, 4, 1'b1, 32'h0000_1000);

        run_instr(0, 0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_upper", {28'd0, pc_plus4_upper}, 32'd0);
        run_instr(0, 0, 1'b0, 32'd0);
        chk("wrap_pc", pc_out, 32'd0);

        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      ($urandom % 3) == 0, $urandom & 32'hFFFF_FFFC);
        end

        imem_ready = 1'b0;
        step();
        chk("midfetch_req", {31'd0, imem_req}, 32'd1);
        #3;
        do_reset();
        run_instr(0, 0, 1'b0, 32'd0);

        run_instr(0, 1, 1'b1, 32'h0000_0102);
        chk("misalign_err", {31'd0, align_err}, 32'd1);
        do_reset();
        chk("err_cleared", {31'd0, align_err}, 32'd0);
        run_instr(1, 0, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and drives the instruction-fetch handshake with instruction memory.
- Supplies PC+4 and its upper nibble to the jump-target multiplexer.
- Accepts the selected next PC back from that multiplexer, on the jump/branch redirect path.
- Sits at the front of the monocycle datapath; adds a fetch/execute sequence so the core can tolerate multi-cycle instruction memory and stalls.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_out  out  32  registered instruction for decode.
- instr_valid  out  1  instr_out holds the instruction at pc.
- stall  in  1  core not ready to retire the current instruction.
- redirect  in  1  next PC comes from next_pc_in (jump/branch taken).
- next_pc_in  in  32  target from the jump/branch multiplexer chain.
- pc_out  out  32  current PC.
- pc_plus4  out  32  pc + 4, wraps modulo 2^32.
- pc_plus4_upper  out  4  pc_plus4[31:28], feeds jump-target formation.
- link_addr  out  32  pc + 4 captured at retire of the last redirect, for jal/jalr.
- retired_cnt  out  CNT_W  count of retired instructions.
- align_err  out  1  sticky misaligned-target flag.

Behaviour:
- States: BOOT, FETCH, EXEC, ERR. Register the state, encoded 2 bits.
- Reset (async, any state, mid-handshake included) sets:
  - state=BOOT, pc=RESET_VECTOR
  - instr_out=0, instr_valid=0, link_addr=0, retired_cnt=0, align_err=0
  - imem_req=0
- BOOT: one cycle with imem_req=0, then FETCH. Gives memory one quiet cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ready.
  - On imem_ready: instr_out<=imem_rdata, instr_valid<=1, go to EXEC.
  - No timeout; the request waits indefinitely.
- EXEC:
  - imem_req=0; instr_valid=1.
  - If stall=1: hold all state; redirect and next_pc_in are ignored.
  - If stall=0, compute target = redirect ? next_pc_in : pc+4.
  - If target[1:0]!=0: align_err<=1, pc unchanged, instr_valid<=0, go to ERR. retired_cnt is not incremented.
  - Otherwise: pc<=target, instr_valid<=0, retired_cnt<=retired_cnt+1 (wraps at 2^CNT_W), go to FETCH.
  - link_addr<=pc+4 on a retire with redirect=1.
- ERR: imem_req=0, instr_valid=0, align_err=1. Only reset exits.
- Combinational outputs (all states):
  - pc_plus4 = pc + 32'd4, carry out discarded.
  - pc_plus4_upper = pc_plus4[31:28].
  - pc_out = pc.
- Minimum latency: 2 cycles per instruction (FETCH with imem_ready already high, plus EXEC).
- Wrap-around: pc=32'hFFFF_FFFC sequential retire gives pc=0, and pc_plus4_upper=4'h0 during that instruction.
- imem_ready outside FETCH is ignored.

Decomposition:
- Shared package/header mips_defs holds:
  - state encodings ST_BOOT=2'd0, ST_FETCH=2'd1, ST_EXEC=2'd2, ST_ERR=2'd3
  - constants PC_INC=32'd4, WORD_ALIGN_MASK=2'b11
- One natural sub-module: pc_adder4 (32-bit +4 incrementer). It is shared by the pc_plus4 output and the sequential-target path.
- The state machine and counters stay in the top module.

Test Plan:
- Reset release with RESET_VECTOR=0 and imem_ready tied high -> BOOT for 1 cycle; imem_addr sequence 0x0,0x4,0x8 at 2 cycles each; retired_cnt=3 after 6 cycles in FETCH/EXEC.
- imem_ready delayed 3 cycles in FETCH -> imem_addr and imem_req stable for the wait; instr_out equals imem_rdata from the ready cycle.
- At pc=0x0040_0020, redirect=1, next_pc_in=0x0040_0100 -> next imem_addr=0x0040_0100, link_addr=0x0040_0024, pc_plus4_upper=4'h0.
- stall=1 for 4 cycles in EXEC while redirect toggles -> pc, retired_cnt and instr_out frozen; the redirect value at stall release takes effect.
- redirect=1, next_pc_in=0x0000_0102 -> align_err=1, pc unchanged, imem_req stays 0; rst pulse returns to BOOT with align_err=0.
- Sequential retire at pc=0xFFFF_FFFC -> pc=0x0000_0000. rst asserted mid-FETCH wait -> imem_req drops immediately and pc=RESET_VECTOR.
